// File: rtl/irq_coalescing_controller.sv
// Interrupt aggregator with sticky pending bits, per-source mask, lowest-index ID
// and programmable hold-off between CPU interrupts. Optional LATENCY counter: IRQ_COALESCE_LATENCY_EN.
module irq_coalescing_controller #(
  parameter int unsigned N_IRQ         = 8,
  parameter logic [15:0] HOLDOFF_RESET = 16'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD
  } state_e;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_RAW     = 3'd2;
  localparam logic [2:0] ADDR_ID      = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;
  localparam logic [2:0] ADDR_LATENCY = 3'd6;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [15:0]      holdoff_q, holdoff_d;
  logic             gie_q, gie_d;
  logic             edge_q, edge_d;
  logic             irq_out_q;
  logic [15:0]      readdata_q, readdata_d;
  logic [15:0]      latency_rd;

  logic             wr_en;
  logic [N_IRQ-1:0] set_v;
  logic [N_IRQ-1:0] clr_v;
  logic [N_IRQ-1:0] enabled_v;
  logic             active;
  logic             id_valid;
  logic [3:0]       id_idx;

  assign wr_en     = chipselect && !write_n;
  assign enabled_v = pending_q & mask_q;
  assign active    = (|enabled_v) && gie_q;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    set_v = edge_q ? (irq_in & ~irq_prev_q) : irq_in;
    clr_v = '0;
    if (wr_en && address == ADDR_PENDING) clr_v = writedata[N_IRQ-1:0];
    // Set is OR-ed in after the clear so a same-cycle capture survives a W1C.
    pending_d = (pending_q & ~clr_v) | set_v;

    mask_d    = mask_q;
    holdoff_d = holdoff_q;
    gie_d     = gie_q;
    edge_d    = edge_q;
    if (wr_en) begin
      unique case (address)
        ADDR_MASK:    mask_d = writedata[N_IRQ-1:0];
        ADDR_HOLDOFF: holdoff_d = writedata;
        ADDR_CTRL: begin
          gie_d  = writedata[0];
          edge_d = writedata[1];
        end
        default: ;
      endcase
    end
  end

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    id_valid = 1'b0;
    id_idx   = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (enabled_v[i]) begin
        id_valid = 1'b1;
        id_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!active) begin
          if (holdoff_q != 16'd0) begin
            state_d = ST_HOLD;
            cnt_d   = holdoff_q - 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == 16'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    readdata_d = 16'd0;
    unique case (address)
      ADDR_PENDING: readdata_d = 16'(pending_q);
      ADDR_MASK:    readdata_d = 16'(mask_q);
      ADDR_RAW:     readdata_d = 16'(irq_in);
      ADDR_ID:      readdata_d = {id_valid, 11'd0, id_idx};
      ADDR_HOLDOFF: readdata_d = holdoff_q;
      ADDR_CTRL:    readdata_d = {14'd0, edge_q, gie_q};
      ADDR_LATENCY: readdata_d = latency_rd;
      default:      readdata_d = 16'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      holdoff_q  <= HOLDOFF_RESET;
      gie_q      <= 1'b0;
      edge_q     <= 1'b0;
      irq_out_q  <= 1'b0;
      readdata_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_in;
      holdoff_q  <= holdoff_d;
      gie_q      <= gie_d;
      edge_q     <= edge_d;
      irq_out_q  <= (state_q == ST_ASSERT);
      readdata_q <= readdata_d;
    end
  end

`ifdef IRQ_COALESCE_LATENCY_EN
  logic [15:0] latency_q, latency_d;

  always_comb begin
    latency_d = latency_q;
    if (state_q == ST_IDLE && state_d == ST_ASSERT) latency_d = 16'd0;
    else if (irq_out_q && latency_q != 16'hFFFF)    latency_d = latency_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) latency_q <= 16'd0;
    else       latency_q <= latency_d;
  end

  assign latency_rd = latency_q;
`else
  assign latency_rd = 16'd0;
`endif

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_irq_coalescing_controller.sv
// Directed self-checking bench for irq_coalescing_controller (N_IRQ=8, HOLDOFF_RESET=7).
module tb_irq_coalescing_controller;

  localparam int          N  = 8;
  localparam logic [15:0] HR = 16'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic [N-1:0]  irq_in;
  logic          irq_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_coalescing_controller #(
    .N_IRQ(N),
    .HOLDOFF_RESET(HR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq_in(irq_in),
    .irq_out(irq_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    @(negedge clk);
    check(tag, readdata, exp);
  endtask

  task automatic wait_irq(input string tag, input logic val, input int budget);
    int n = 0;
    while (irq_out !== val && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {15'd0, irq_out}, {15'd0, val});
  endtask

  // Waits for irq_out to fall, then counts the low cycles until it rises again.
  task automatic measure_low(input string tag, input int exp);
    int n = 0;
    int low = 0;
    while (irq_out !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    while (irq_out === 1'b0 && low < 100) begin
      low++;
      step(1);
    end
    check(tag, 16'(low), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'd0;
    irq_in     = '0;
    step(3);
    reset = 1'b0;

    check("rst_irq_out", {15'd0, irq_out}, 16'd0);
    check("rst_readdata", readdata, 16'd0);
    expect_reg("rst_pending", 3'd0, 16'h0000);
    expect_reg("rst_mask", 3'd1, 16'h0000);
    expect_reg("rst_ctrl", 3'd5, 16'h0000);
    expect_reg("rst_holdoff", 3'd4, HR);
    expect_reg("rst_addr7", 3'd7, 16'h0000);

    // Level mode, single-cycle pulse on source 0
    reg_write(3'd4, 16'd0);
    reg_write(3'd1, 16'h0001);
    reg_write(3'd5, 16'h0001);
    irq_in = 8'h01;
    step(1);
    irq_in = 8'h00;
    check("lvl_out_c1", {15'd0, irq_out}, 16'd0);
    step(1);
    check("lvl_out_c2", {15'd0, irq_out}, 16'd0);
    step(1);
    check("lvl_out_c3", {15'd0, irq_out}, 16'd1);
    expect_reg("lvl_pending", 3'd0, 16'h0001);
    expect_reg("lvl_id", 3'd3, 16'h8000);
    expect_reg("lvl_raw", 3'd2, 16'h0000);
    check("lvl_sticky", {15'd0, irq_out}, 16'd1);
    reg_write(3'd0, 16'h0001);
    step(2);
    check("lvl_w1c_fall", {15'd0, irq_out}, 16'd0);
    expect_reg("lvl_pending_clr", 3'd0, 16'h0000);

    // Priority and mask gating
    irq_in = 8'h24;
    reg_write(3'd1, 16'h00FF);
    expect_reg("prio_id_2", 3'd3, 16'h8002);
    irq_in = 8'h20;
    reg_write(3'd0, 16'h0004);
    expect_reg("prio_id_5", 3'd3, 16'h8005);
    expect_reg("prio_pending", 3'd0, 16'h0020);
    reg_write(3'd1, 16'h0000);
    expect_reg("mask_id_none", 3'd3, 16'h0000);
    expect_reg("mask_pending_kept", 3'd0, 16'h0020);
    wait_irq("mask_irq_fall", 1'b0, 5);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    reg_write(3'd1, 16'h00FF);
    expect_reg("prio_cleared", 3'd0, 16'h0000);

    // Edge mode: hold source 1 high, clear at cycle 5
    reg_write(3'd5, 16'h0003);
    irq_in = 8'h02;
    step(4);
    reg_write(3'd0, 16'h0002);
    expect_reg("edge_after_clr", 3'd0, 16'h0000);
    step(8);
    expect_reg("edge_held_high", 3'd0, 16'h0000);
    step(5);
    irq_in = 8'h00;
    step(2);
    expect_reg("edge_low", 3'd0, 16'h0000);
    irq_in = 8'h02;
    step(1);
    expect_reg("edge_new_rise", 3'd0, 16'h0002);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    reg_write(3'd5, 16'h0001);
    step(3);

    // Coalescing hold-off
    reg_write(3'd4, 16'd10);
    irq_in = 8'h01;
    wait_irq("coal_assert", 1'b1, 10);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    irq_in = 8'h01;
    measure_low("coal_low_h10", 11);
    reg_write(3'd4, 16'd0);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    irq_in = 8'h01;
    measure_low("coal_low_h0", 1);

    // Simultaneous W1C and level set on bit 3
    irq_in = 8'h08;
    reg_write(3'd1, 16'h0008);
    reg_write(3'd0, 16'h00FF);
    step(3);
    check("sim_pre_out", {15'd0, irq_out}, 16'd1);
    reg_write(3'd0, 16'h0008);
    check("sim_out_c0", {15'd0, irq_out}, 16'd1);
    step(2);
    check("sim_out_c2", {15'd0, irq_out}, 16'd1);
    expect_reg("sim_pending", 3'd0, 16'h0008);
    check("sim_out_end", {15'd0, irq_out}, 16'd1);

    // Assertion duration counter (reads 0 when the counter is not built)
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    step(3);
    check("lat_idle", {15'd0, irq_out}, 16'd0);
    irq_in = 8'h08;
    wait_irq("lat_assert", 1'b1, 10);
    step(97);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h0008);
    wait_irq("lat_fall", 1'b0, 5);
    step(3);
`ifdef IRQ_COALESCE_LATENCY_EN
    expect_reg("latency", 3'd6, 16'd100);
`else
    expect_reg("latency_absent", 3'd6, 16'd0);
`endif

    // Reset while in HOLD
    reg_write(3'd4, 16'd20);
    irq_in = 8'h08;
    wait_irq("hold_assert", 1'b1, 10);
    irq_in = 8'h00;
    reg_write(3'd0, 16'h00FF);
    step(3);
    check("hold_out_low", {15'd0, irq_out}, 16'd0);
    irq_in = 8'h08;
    step(1);
    expect_reg("hold_latch", 3'd0, 16'h0008);
    check("hold_still_low", {15'd0, irq_out}, 16'd0);
    reset  = 1'b1;
    irq_in = 8'h00;
    step(1);
    reset = 1'b0;
    check("mid_rst_out", {15'd0, irq_out}, 16'd0);
    expect_reg("mid_rst_pending", 3'd0, 16'h0000);
    expect_reg("mid_rst_mask", 3'd1, 16'h0000);
    expect_reg("mid_rst_holdoff", 3'd4, HR);
    reg_write(3'd1, 16'h0008);
    reg_write(3'd5, 16'h0001);
    irq_in = 8'h08;
    wait_irq("mid_rst_idle", 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
